// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
//   Frame constants and FSM encodings shared by the UART receiver files.
//   The transmitter side uses the same frame constants.
//   Contents:
//     DATA_BITS          data bits per frame
//     DEFAULT_OVERSAMPLE ticks per bit period when the instantiator does not override it
//     ST_*               FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3)
//     calc_div()         clocks per oversample tick
package uart_rx_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef logic [1:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 2'd0;
  localparam rx_state_t ST_START = 2'd1;
  localparam rx_state_t ST_DATA  = 2'd2;
  localparam rx_state_t ST_STOP  = 2'd3;

  // Integer division, clamped to 1 so a very fast baud rate still produces a tick
  // every clock instead of a zero-length counter.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int div;
    div = clk_freq / (baud * oversample);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick
//   Oversample tick generator: one-clock pulse every DIV clocks.
//   Ports:
//     clk    in  system clock
//     reset  in  synchronous active-high reset, count returns to 0
//     clear  in  forces the count to 0; no tick is produced in that cycle
//     tick   out one-clock pulse when the count reaches DIV-1
module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // A clear is used to realign the sampling phase to a fresh start edge, so it must
  // also suppress the tick that would otherwise fire on the old phase.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CW'(1);
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 serial receiver with 16x (OVERSAMPLE) oversampling and mid-bit sampling.
//   Ports:
//     clk        in  system clock, rising edge
//     reset      in  synchronous active-high reset
//     serial_rx  in  asynchronous serial line, idle high
//     data_out   out last correctly framed byte, held until the next good frame
//     data_valid out one-clock pulse, data_out updated this cycle
//     frame_err  out one-clock pulse, stop bit sampled low, data_out unchanged
//     busy       out high from start-bit detection until return to IDLE
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [TCW-1:0] TCNT_MID  = TCW'(OVERSAMPLE / 2 - 1);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BCNT_LAST = BCW'(DATA_BITS - 1);

  logic                 sync1_q, sync1_d;
  logic                 rx_s_q, rx_s_d;
  rx_state_t            state_q, state_d;
  logic [TCW-1:0]       tcnt_q, tcnt_d;
  logic [BCW-1:0]       bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;

  logic tick;
  logic tick_clear;

  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (tick_clear),
    .tick  (tick)
  );

  // Next-state logic. "armed" is the break guard: after a frame (or a false start)
  // the line must be seen high for at least one clock before a new start is taken,
  // so a held-low line after a framing error cannot retrigger endlessly.
  always_comb begin
    sync1_d      = serial_rx;
    rx_s_d       = sync1_q;
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    busy_d       = busy_q;
    tick_clear   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d    = ST_START;
          busy_d     = 1'b1;
          tcnt_d     = '0;
          armed_d    = 1'b0;
          tick_clear = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (tcnt_q == TCNT_MID) begin
            tcnt_d = '0;
            if (!rx_s_q) begin
              state_d = ST_DATA;
              bcnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d = '0;
            if (MSB_FIRST) begin
              shift_d = {shift_q[DATA_BITS-2:0], rx_s_q};
            end else begin
              shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            end
            if (bcnt_q == BCNT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end

      ST_STOP: begin
        // Leaving at mid-stop puts the FSM back in IDLE half a bit early, which is
        // what lets a start bit that directly follows the stop bit be caught.
        if (tick) begin
          if (tcnt_q == TCNT_LAST) begin
            tcnt_d  = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            if (rx_s_q) begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
              armed_d      = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Synchronizer flops reset to 1 so the line looks idle straight out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Self-checking bench for uart_rx at CLK_FREQ=1_600_000, BAUD=10_000 (160 clk/bit).
//   Frames are built bit by bit on the line; the expected byte, pulse counts and
//   held data_out value come from a frame-level model (last good byte wins).
module tb_uart_rx;

  localparam int BIT_CLKS = 160;

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         period;
    int         gapAfter;
    int         expValid;
    int         expErr;
    logic [7:0] expData;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  int   validCount = 0;
  int   errCount = 0;
  logic bothSeen = 1'b0;
  logic [7:0] modelData;

  vec_t vecs [7];

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ   (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .MSB_FIRST  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_rx  (serial_rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Pulse monitor: every clock a pulse is high counts once, so a stretched pulse
  // shows up as an extra event against the model.
  always @(negedge clk) begin
    if (data_valid) validCount++;
    if (frame_err) errCount++;
    if (data_valid && frame_err) bothSeen = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drives the line with one level for a number of clocks, changing at negedge.
  task automatic applyStimulus(input logic level, input int clks);
    serial_rx = level;
    repeat (clks) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int period);
    applyStimulus(1'b0, period);
    for (int i = 7; i >= 0; i--) applyStimulus(b[i], period);
    applyStimulus(stopBit, period);
  endtask

  // Sends one frame and checks the frame-level outcome at the end of the stop bit.
  task automatic runFrame(input string name, input logic [7:0] b, input logic stopBit,
                          input int period, input int gapAfter,
                          input int expValid, input int expErr, input logic [7:0] expData);
    int v0;
    int e0;
    v0 = validCount;
    e0 = errCount;
    sendFrame(b, stopBit, period);
    checkOutput({name, " valid"}, validCount - v0, expValid);
    checkOutput({name, " err"}, errCount - e0, expErr);
    checkOutput({name, " data"}, data_out, expData);
    checkOutput({name, " busy"}, busy, 1'b0);
    applyStimulus(1'b1, gapAfter);
  endtask

  initial begin
    int v0;
    int e0;
    int busyClks;
    logic [7:0] rb;
    logic rs;
    int rp;
    int rg;

    vecs[0] = '{8'hA5, 1'b1, 160, 40, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 160, 40, 0, 1, 8'hA5};
    vecs[2] = '{8'h81, 1'b1, 160, 40, 1, 0, 8'h81};
    vecs[3] = '{8'h00, 1'b1, 160, 0,  1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 160, 40, 1, 0, 8'hFF};
    vecs[5] = '{8'h55, 1'b1, 165, 40, 1, 0, 8'h55};
    vecs[6] = '{8'h55, 1'b1, 155, 40, 1, 0, 8'h55};

    reset = 1'b1;
    serial_rx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset data_out", data_out, 8'h00);
    checkOutput("reset data_valid", data_valid, 1'b0);
    checkOutput("reset frame_err", frame_err, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    reset = 1'b0;
    modelData = 8'h00;
    applyStimulus(1'b1, 20);

    for (int i = 0; i < 7; i++) begin
      runFrame($sformatf("vec%0d", i), vecs[i].data, vecs[i].stopBit, vecs[i].period,
               vecs[i].gapAfter, vecs[i].expValid, vecs[i].expErr, vecs[i].expData);
    end
    modelData = 8'h55;

    // Short low glitch: false start, busy only for about half a bit.
    v0 = validCount;
    e0 = errCount;
    busyClks = 0;
    serial_rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busyClks++;
    end
    serial_rx = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) busyClks++;
    end
    checkOutput("glitch busy window", (busyClks >= 70 && busyClks <= 90), 1'b1);
    checkOutput("glitch busy low", busy, 1'b0);
    checkOutput("glitch no valid", validCount - v0, 0);
    checkOutput("glitch no err", errCount - e0, 0);
    checkOutput("glitch data", data_out, modelData);

    // Reset in the middle of the bit slot carrying data[4] of 0x5A.
    v0 = validCount;
    e0 = errCount;
    applyStimulus(1'b0, BIT_CLKS);
    for (int i = 7; i >= 5; i--) applyStimulus(rb_const(i), BIT_CLKS);
    applyStimulus(1'b1, BIT_CLKS / 2);
    checkOutput("pre-reset busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset data_out", data_out, 8'h00);
    checkOutput("midreset data_valid", data_valid, 1'b0);
    checkOutput("midreset frame_err", frame_err, 1'b0);
    checkOutput("midreset busy", busy, 1'b0);
    modelData = 8'h00;
    applyStimulus(1'b1, 12 * BIT_CLKS);
    checkOutput("midreset no valid", validCount - v0, 0);
    checkOutput("midreset no err", errCount - e0, 0);
    runFrame("after reset", 8'h5A, 1'b1, BIT_CLKS, 40, 1, 0, 8'h5A);
    modelData = 8'h5A;

    // Random frames against the frame-level model.
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      rp = $urandom_range(155, 165);
      rg = rs ? $urandom_range(0, 30) : $urandom_range(20, 60);
      if (rs) modelData = rb;
      runFrame($sformatf("rand%0d", i), rb, rs, rp, rg, rs ? 1 : 0, rs ? 0 : 1, modelData);
    end

    checkOutput("valid/err exclusive", bothSeen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bits of 0x5A for the aborted frame, by data index.
  function automatic logic rb_const(input int idx);
    logic [7:0] v;
    v = 8'h5A;
    return v[idx];
  endfunction

endmodule
